// File: rtl/rf_sched_pkg.sv
// Shared types and defaults for the register-file write scheduler.
package rf_sched_pkg;

    localparam int unsigned DEF_WORD_SIZE = 16;
    localparam int unsigned DEF_ADDR_BITS = 2;
    localparam int unsigned DEF_REG_SIZE  = 1 << DEF_ADDR_BITS;

    typedef enum logic {
        CLEAR = 1'b0,
        ARB   = 1'b1
    } sched_state_e;

    // Grant index width: max(1, clog2(n)).
    function automatic int unsigned gid_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rf_rr_arbiter.sv
// Round-robin grant over NUM_REQ requesters with a registered rotating pointer.
// Build with RF_SCHED_FIXED_PRIO_EN for fixed priority (index 0 highest), no pointer.
module rf_rr_arbiter
    import rf_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 2,
    parameter int unsigned GID_BITS = gid_width(NUM_REQ)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REQ-1:0]  req,
    input  logic                advance,
    output logic [NUM_REQ-1:0]  grant_c,
    output logic [GID_BITS-1:0] gid_c
);

    logic [GID_BITS-1:0] base_c;
    logic                found_c;
    int unsigned         idx_c;

`ifdef RF_SCHED_FIXED_PRIO_EN
    logic unused_c;
    assign base_c   = '0;
    assign unused_c = &{1'b0, clk, reset, advance};
`else
    logic [GID_BITS-1:0] ptr_q, ptr_d;

    // Pointer moves to the slot just after the requester that won this cycle.
    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = (gid_c == GID_BITS'(NUM_REQ - 1)) ? '0 : gid_c + GID_BITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign base_c = ptr_q;
`endif

    // First valid requester at or after base, wrapping around.
    always_comb begin
        grant_c = '0;
        gid_c   = '0;
        found_c = 1'b0;
        idx_c   = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx_c = (32'(base_c) + k) % NUM_REQ;
            if (!found_c && req[idx_c]) begin
                found_c        = 1'b1;
                grant_c[idx_c] = 1'b1;
                gid_c          = GID_BITS'(idx_c);
            end
        end
    end

endmodule

// File: rtl/rf_write_scheduler.sv
// Owns the register-file write port: sequential clear after reset/command, then
// arbitrated requester writes with one-cycle latency. Option: RF_SCHED_FIXED_PRIO_EN.
module rf_write_scheduler
    import rf_sched_pkg::*;
#(
    parameter int unsigned WORD_SIZE = DEF_WORD_SIZE,
    parameter int unsigned ADDR_BITS = DEF_ADDR_BITS,
    parameter int unsigned NUM_REQ   = 2,
    parameter int unsigned GID_BITS  = gid_width(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*ADDR_BITS-1:0]   req_addr,
    input  logic [NUM_REQ*WORD_SIZE-1:0]   req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic                           clear_start,
    output logic                           busy,
    output logic                           rf_we,
    output logic [ADDR_BITS-1:0]           rf_waddr,
    output logic [WORD_SIZE-1:0]           rf_wdata,
    output logic [GID_BITS-1:0]            grant_id
);

    localparam int unsigned REG_SIZE = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(REG_SIZE - 1);

    sched_state_e          state_q, state_d;
    logic [ADDR_BITS-1:0]  cnt_q, cnt_d;
    logic                  rf_we_q, rf_we_d;
    logic [ADDR_BITS-1:0]  rf_waddr_q, rf_waddr_d;
    logic [WORD_SIZE-1:0]  rf_wdata_q, rf_wdata_d;
    logic [GID_BITS-1:0]   grant_id_q, grant_id_d;
    logic                  busy_q, busy_d;

    logic [NUM_REQ-1:0]    grant_c;
    logic [GID_BITS-1:0]   gid_c;
    logic                  arb_en_c;
    logic                  xfer_c;

    rf_rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .GID_BITS (GID_BITS)
    ) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req_valid),
        .advance (xfer_c),
        .grant_c (grant_c),
        .gid_c   (gid_c)
    );

    // Grant is already masked by req_valid, so any ready bit is a transfer.
    assign arb_en_c  = !reset && (state_q == ARB) && !clear_start;
    assign req_ready = arb_en_c ? grant_c : '0;
    assign xfer_c    = |req_ready;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        grant_id_d = grant_id_q;
        busy_d     = 1'b0;
        case (state_q)
            CLEAR: begin
                rf_we_d    = 1'b1;
                rf_waddr_d = cnt_q;
                rf_wdata_d = '0;
                busy_d     = 1'b1;
                cnt_d      = cnt_q + ADDR_BITS'(1);
                if (cnt_q == LAST_ADDR) begin
                    state_d = ARB;
                end
            end
            ARB: begin
                if (clear_start) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end else if (xfer_c) begin
                    rf_we_d    = 1'b1;
                    rf_waddr_d = req_addr[32'(gid_c) * ADDR_BITS +: ADDR_BITS];
                    rf_wdata_d = req_data[32'(gid_c) * WORD_SIZE +: WORD_SIZE];
                    grant_id_d = gid_c;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= CLEAR;
            cnt_q      <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            grant_id_q <= '0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            grant_id_q <= grant_id_d;
            busy_q     <= busy_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign grant_id = grant_id_q;
    assign busy     = busy_q;

endmodule
